// File: rtl/postif_id.sv
// postif_id: fetch-to-decode pipeline register tracking outstanding I-cache replies (wait/hold/drop).
// Optional feature: define POSTIF_ID_PERF_CNT_EN to build the fetch-wait cycle counter on wait_cnt_o.
module postif_id (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] exception_type_i,
    input  logic        inst_ren_i,
    input  logic        inst_ok_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] exception_type_o,
    output logic        valid_o,
    output logic        wait_stall_o,
    output logic [31:0] wait_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_n;

    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_exc;
    logic        r_valid;

    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_exc;
    logic        r_hold_valid;

    logic        w_fetching;
    logic        w_pending;
    logic        w_arrive;
    logic        w_load_in;
    logic        w_load_hold;
    logic        w_capture;
    logic        w_bubble;
    logic        w_wait_stall;
    logic [31:0] w_inst_in;

    always_comb begin
        w_fetching   = (r_state == S_IDLE) || (r_state == S_WAIT);
        w_pending    = w_fetching && inst_ren_i && !inst_ok_i;
        w_arrive     = w_fetching && !(inst_ren_i && !inst_ok_i);
        // With no read issued the slot passes through carrying a zero instruction.
        w_inst_in    = inst_ren_i ? inst_i : '0;
        w_load_in    = !flush_i && w_arrive && !stall_i;
        w_capture    = !flush_i && w_arrive && stall_i;
        w_load_hold  = !flush_i && (r_state == S_HOLD) && !stall_i;
        w_bubble     = flush_i || (w_pending && !stall_i);
        w_wait_stall = (r_state == S_HOLD) || (r_state == S_DROP) || w_pending;
    end

    always_comb begin
        w_state_n = r_state;
        if (flush_i) begin
            // A reply still owed to the bus must be swallowed; one arriving now is consumed here.
            if (w_pending || ((r_state == S_DROP) && !inst_ok_i)) begin
                w_state_n = S_DROP;
            end else begin
                w_state_n = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_pending) begin
                        w_state_n = S_WAIT;
                    end else if (stall_i) begin
                        w_state_n = S_HOLD;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        w_state_n = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (inst_ok_i) begin
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc         <= '0;
            r_inst       <= '0;
            r_exc        <= '0;
            r_valid      <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_inst  <= '0;
            r_hold_exc   <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_load_in) begin
                r_pc    <= pc_i;
                r_inst  <= w_inst_in;
                r_exc   <= exception_type_i;
                r_valid <= inst_valid_i;
            end else if (w_load_hold) begin
                r_pc    <= r_hold_pc;
                r_inst  <= r_hold_inst;
                r_exc   <= r_hold_exc;
                r_valid <= r_hold_valid;
            end else if (w_bubble) begin
                r_valid <= 1'b0;
            end

            if (w_capture) begin
                r_hold_pc    <= pc_i;
                r_hold_inst  <= w_inst_in;
                r_hold_exc   <= exception_type_i;
                r_hold_valid <= inst_valid_i;
            end else if (flush_i || w_load_hold) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

`ifdef POSTIF_ID_PERF_CNT_EN
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
        end else if (w_wait_stall) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign wait_cnt_o = r_wait_cnt;
`else
    assign wait_cnt_o = '0;
`endif

    assign pc_o             = r_pc;
    assign inst_o           = r_inst;
    assign exception_type_o = r_exc;
    assign valid_o          = r_valid;
    assign wait_stall_o     = w_wait_stall;

endmodule

// File: tb/tb_postif_id.sv
// tb_postif_id: table-driven directed vectors plus randomized stimulus against a flag-based reference model.
module tb_postif_id;

    logic        clk;
    logic        resetn;
    logic [31:0] pc_i, inst_i, exception_type_i;
    logic        inst_ren_i, inst_ok_i, inst_valid_i, stall_i, flush_i;
    logic [31:0] pc_o, inst_o, exception_type_o, wait_cnt_o;
    logic        valid_o, wait_stall_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        s_ws;

    postif_id dut (
        .clk              (clk),
        .resetn           (resetn),
        .pc_i             (pc_i),
        .inst_i           (inst_i),
        .exception_type_i (exception_type_i),
        .inst_ren_i       (inst_ren_i),
        .inst_ok_i        (inst_ok_i),
        .inst_valid_i     (inst_valid_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .exception_type_o (exception_type_o),
        .valid_o          (valid_o),
        .wait_stall_o     (wait_stall_o),
        .wait_cnt_o       (wait_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an output entry, an optional parked entry, and a "reply owed but unwanted" flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
        logic        valid;
    } ent_t;

    ent_t        m_out, m_buf;
    bit          m_buf_full, m_dropping;
    logic [31:0] m_cnt;

    function automatic bit m_ws(input logic ren, input logic ok);
        return m_buf_full || m_dropping || (ren && !ok);
    endfunction

    task automatic m_reset();
        m_out = '0; m_buf = '0; m_buf_full = 0; m_dropping = 0; m_cnt = '0;
    endtask

    task automatic m_update(input logic rn, input logic ren, input logic ok, input logic vld,
                            input logic st, input logic fl, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] exc);
        ent_t e;
        bit   ws;
        ws = m_ws(ren, ok);
        e  = '{pc: pc, inst: (ren ? inst : 32'h0), exc: exc, valid: vld};
        if (!rn) begin
            m_reset();
            return;
        end
`ifdef POSTIF_ID_PERF_CNT_EN
        if (ws) m_cnt = m_cnt + 1;
`endif
        if (fl) begin
            m_out.valid = 0;
            if (m_dropping) m_dropping = !ok;
            else            m_dropping = !m_buf_full && ren && !ok;
            m_buf_full = 0;
        end else if (m_dropping) begin
            if (ok) m_dropping = 0;
        end else if (m_buf_full) begin
            if (!st) begin
                m_out = m_buf;
                m_buf_full = 0;
            end
        end else if (ren && !ok) begin
            if (!st) m_out.valid = 0;
        end else if (!st) begin
            m_out = e;
        end else begin
            m_buf = e;
            m_buf_full = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check the combinational stall, then the registered outputs.
    task automatic step(input logic rn, input logic ren, input logic ok, input logic vld,
                        input logic st, input logic fl, input logic [31:0] pc,
                        input logic [31:0] inst, input logic [31:0] exc);
        resetn = rn; inst_ren_i = ren; inst_ok_i = ok; inst_valid_i = vld;
        stall_i = st; flush_i = fl; pc_i = pc; inst_i = inst; exception_type_i = exc;
        #1;
        s_ws = wait_stall_o;
        chk("wait_stall_o", {31'b0, wait_stall_o}, {31'b0, m_ws(ren, ok)});
        @(posedge clk);
        m_update(rn, ren, ok, vld, st, fl, pc, inst, exc);
        #1;
        chk("pc_o", pc_o, m_out.pc);
        chk("inst_o", inst_o, m_out.inst);
        chk("exception_type_o", exception_type_o, m_out.exc);
        chk("valid_o", {31'b0, valid_o}, {31'b0, m_out.valid});
        chk("wait_cnt_o", wait_cnt_o, m_cnt);
        @(negedge clk);
    endtask

    typedef struct {
        logic        ren, ok, vld, st, fl;
        logic [31:0] pc, inst, exc;
        logic        e_ws;
        logic [31:0] e_pc, e_inst, e_exc;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic ren, input logic ok, input logic vld, input logic st,
                                input logic fl, input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] exc, input logic e_ws, input logic [31:0] e_pc,
                                input logic [31:0] e_inst, input logic [31:0] e_exc,
                                input logic e_valid);
        vec_t v;
        v.ren = ren; v.ok = ok; v.vld = vld; v.st = st; v.fl = fl;
        v.pc = pc; v.inst = inst; v.exc = exc;
        v.e_ws = e_ws; v.e_pc = e_pc; v.e_inst = e_inst; v.e_exc = e_exc; v.e_valid = e_valid;
        return v;
    endfunction

    vec_t        vecs[17];
    logic [31:0] exp_cnt;

    initial begin
        //                ren ok vld st fl  pc            inst          exc       ws  e_pc          e_inst        e_exc     e_v
        vecs[0]  = mk(1, 1, 1, 0, 0, 32'hBFC00000, 32'h24080001, 32'h0,  0, 32'hBFC00000, 32'h24080001, 32'h0,  1);
        vecs[1]  = mk(1, 0, 1, 0, 0, 32'hBFC00004, 32'h0,        32'h0,  1, 32'hBFC00000, 32'h24080001, 32'h0,  0);
        vecs[2]  = mk(1, 0, 1, 0, 0, 32'hBFC00004, 32'h0,        32'h0,  1, 32'hBFC00000, 32'h24080001, 32'h0,  0);
        vecs[3]  = mk(1, 0, 1, 0, 0, 32'hBFC00004, 32'h0,        32'h0,  1, 32'hBFC00000, 32'h24080001, 32'h0,  0);
        vecs[4]  = mk(1, 1, 1, 0, 0, 32'hBFC00004, 32'h00000000, 32'h0,  0, 32'hBFC00004, 32'h00000000, 32'h0,  1);
        vecs[5]  = mk(1, 1, 1, 1, 0, 32'hBFC00008, 32'h3C1DA000, 32'h0,  0, 32'hBFC00004, 32'h00000000, 32'h0,  1);
        vecs[6]  = mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,  1, 32'hBFC00004, 32'h00000000, 32'h0,  1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1, 32'hBFC00008, 32'h3C1DA000, 32'h0,  1);
        vecs[8]  = mk(1, 0, 1, 0, 0, 32'hBFC0000C, 32'h0,        32'h0,  1, 32'hBFC00008, 32'h3C1DA000, 32'h0,  0);
        vecs[9]  = mk(1, 0, 1, 0, 1, 32'hBFC0000C, 32'h0,        32'h0,  1, 32'hBFC00008, 32'h3C1DA000, 32'h0,  0);
        vecs[10] = mk(1, 0, 1, 0, 0, 32'hBFC0000C, 32'h0,        32'h0,  1, 32'hBFC00008, 32'h3C1DA000, 32'h0,  0);
        vecs[11] = mk(1, 1, 1, 0, 0, 32'hBFC0000C, 32'h8C020004, 32'h0,  1, 32'hBFC00008, 32'h3C1DA000, 32'h0,  0);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h12345678, 32'h0,  0, 32'h0,        32'h0,        32'h0,  0);
        vecs[13] = mk(0, 0, 1, 0, 0, 32'h00000100, 32'hDEADBEEF, 32'h10, 0, 32'h00000100, 32'h0,        32'h10, 1);
        vecs[14] = mk(1, 1, 1, 1, 0, 32'h00000200, 32'h11111111, 32'h20, 0, 32'h00000100, 32'h0,        32'h10, 1);
        vecs[15] = mk(0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h0,  1, 32'h00000100, 32'h0,        32'h10, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 32'h00000300, 32'h00000055, 32'h0,  0, 32'h00000300, 32'h0,        32'h0,  0);

        resetn = 0; inst_ren_i = 0; inst_ok_i = 0; inst_valid_i = 0; stall_i = 0; flush_i = 0;
        pc_i = '0; inst_i = '0; exception_type_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();

        chk("reset pc_o", pc_o, 32'h0);
        chk("reset inst_o", inst_o, 32'h0);
        chk("reset exception_type_o", exception_type_o, 32'h0);
        chk("reset valid_o", {31'b0, valid_o}, 32'h0);
        chk("reset wait_cnt_o", wait_cnt_o, 32'h0);

        for (int i = 0; i < 17; i++) begin
            step(1, vecs[i].ren, vecs[i].ok, vecs[i].vld, vecs[i].st, vecs[i].fl,
                 vecs[i].pc, vecs[i].inst, vecs[i].exc);
            chk($sformatf("vec%0d ws", i), {31'b0, s_ws}, {31'b0, vecs[i].e_ws});
            chk($sformatf("vec%0d pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("vec%0d inst", i), inst_o, vecs[i].e_inst);
            chk($sformatf("vec%0d exc", i), exception_type_o, vecs[i].e_exc);
            chk($sformatf("vec%0d valid", i), {31'b0, valid_o}, {31'b0, vecs[i].e_valid});
        end

        // Reset while an entry is parked in the hold buffer.
        step(1, 1, 1, 1, 1, 0, 32'hA0, 32'hCAFE0001, 32'h4);
        step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        chk("hold-reset pc_o", pc_o, 32'h0);
        chk("hold-reset inst_o", inst_o, 32'h0);
        chk("hold-reset exc", exception_type_o, 32'h0);
        chk("hold-reset valid_o", {31'b0, valid_o}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("post-reset ws", {31'b0, s_ws}, 32'h0);
        chk("post-reset valid_o", {31'b0, valid_o}, 32'h0);

        // Wait-cycle counter: five pending cycles from reset, then reset mid-wait.
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
`ifdef POSTIF_ID_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        chk("wait_cnt after 5", wait_cnt_o, exp_cnt);
        step(0, 1, 0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("wait-reset ws", {31'b0, s_ws}, 32'h0);
        chk("wait-reset cnt", wait_cnt_o, 32'h0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(3) != 0), $urandom_range(1),
                 ($urandom_range(7) != 0), ($urandom_range(2) == 0), ($urandom_range(9) == 0),
                 $urandom, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
